// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sequencer slice.
// Holds the FSM state encoding and the default expected truth table.
package tts_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // 3-input majority: output is 1 at indices 3, 5, 6 and 7.
  localparam logic [7:0] MAJ3_TT = 8'hE8;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_DRIVE = S_DRIVE,
    ST_DONE  = S_DONE
  } state_t;

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// settle_timer: 4-bit settle counter for the truth-table sequencer.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   clr  - synchronous clear (count back to 0)
//   en   - count enable
//   tc   - terminal count, high while count == SETTLE-1
// The count wraps to 0 on the enabled cycle where tc is high, so each
// vector gets exactly SETTLE cycles.
module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [3:0] TC_VAL = 4'(SETTLE - 1);

  logic [3:0] count_r;

  // Settle counter: cleared outside DRIVE, wraps at terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 4'd0;
    end else if (clr) begin
      count_r <= 4'd0;
    end else if (en) begin
      if (tc) begin
        count_r <= 4'd0;
      end else begin
        count_r <= count_r + 4'd1;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == TC_VAL);

endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: walks a 3-input, 2-output combinational unit
// through all eight input vectors, captures both outputs into truth-table
// registers, flags any disagreement and checks y1 against EXPECTED.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   start           - run request, honoured only in IDLE
//   y1, y2          - function-unit outputs being sampled
//   a, b, c         - drive vector (a = idx[2], b = idx[1], c = idx[0])
//   busy            - high while vectors are applied
//   done            - one-cycle pulse at end of run
//   tt1, tt2        - captured truth tables (bit i = output at index i)
//   diff            - sticky y1/y2 disagreement flag for the current run
//   first_diff      - index of first disagreement, 0 if none
//   pass            - !diff && tt1 == EXPECTED, valid from done onward
module truth_table_sequencer
  import tts_pkg::*;
#(
  parameter int         SETTLE   = 1,
  parameter logic [7:0] EXPECTED = MAJ3_TT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y1,
  input  logic       y2,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt1,
  output logic [7:0] tt2,
  output logic       diff,
  output logic [2:0] first_diff,
  output logic       pass
);

  state_t     state_r;
  logic [2:0] idx_r;
  logic       tc_s;
  logic       timer_clr_s;
  logic       timer_en_s;
  logic [7:0] tt1_next_s;
  logic [7:0] tt2_next_s;
  logic       diff_next_s;
  logic [2:0] first_diff_next_s;
  logic [2:0] idx_next_s;

  assign timer_en_s  = (state_r == ST_DRIVE);
  assign timer_clr_s = (state_r != ST_DRIVE);

  settle_timer #(
    .SETTLE(SETTLE)
  ) u_settle_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr_s),
    .en  (timer_en_s),
    .tc  (tc_s)
  );

  // Capture values as they will look after sampling the current index;
  // pass is computed from these so the last vector is included.
  always_comb begin
    tt1_next_s         = tt1;
    tt2_next_s         = tt2;
    tt1_next_s[idx_r]  = y1;
    tt2_next_s[idx_r]  = y2;
    idx_next_s         = idx_r + 3'd1;
    if ((y1 != y2) && !diff) begin
      diff_next_s       = 1'b1;
      first_diff_next_s = idx_r;
    end else begin
      diff_next_s       = diff;
      first_diff_next_s = first_diff;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= 3'd0;
      a          <= 1'b0;
      b          <= 1'b0;
      c          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tt1        <= 8'd0;
      tt2        <= 8'd0;
      diff       <= 1'b0;
      first_diff <= 3'd0;
      pass       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          a    <= 1'b0;
          b    <= 1'b0;
          c    <= 1'b0;
          if (start) begin
            state_r    <= ST_DRIVE;
            idx_r      <= 3'd0;
            busy       <= 1'b1;
            tt1        <= 8'd0;
            tt2        <= 8'd0;
            diff       <= 1'b0;
            first_diff <= 3'd0;
            pass       <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (tc_s) begin
            tt1        <= tt1_next_s;
            tt2        <= tt2_next_s;
            diff       <= diff_next_s;
            first_diff <= first_diff_next_s;
            if (idx_r == 3'd7) begin
              state_r <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              a       <= 1'b0;
              b       <= 1'b0;
              c       <= 1'b0;
              pass    <= !diff_next_s && (tt1_next_s == EXPECTED);
            end else begin
              idx_r <= idx_next_s;
              a     <= idx_next_s[2];
              b     <= idx_next_s[1];
              c     <= idx_next_s[0];
            end
          end else begin
            // Hold the current vector until the settle time expires.
            a <= idx_r[2];
            b <= idx_r[1];
            c <= idx_r[0];
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          idx_r   <= 3'd0;
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= 3'd0;
          busy    <= 1'b0;
          done    <= 1'b0;
          a       <= 1'b0;
          b       <= 1'b0;
          c       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench for truth_table_sequencer: one instance with
// SETTLE=1 and one with SETTLE=3, each beside a behavioural function unit
// whose behaviour is selected by 'mode'.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       sel;
  int         mode;
  logic [7:0] tv1, tv2;
  int         checks = 0;
  int         failures = 0;

  logic a1, b1, c1, busy1, done1, diff1, pass1, y1_1, y2_1;
  logic [7:0] tt1_1, tt2_1;
  logic [2:0] fd1;
  logic a3, b3, c3, busy3, done3, diff3, pass3, y1_3, y2_3;
  logic [7:0] tt1_3, tt2_3;
  logic [2:0] fd3;
  logic start1, start3;

  assign start1 = start & ~sel;
  assign start3 = start & sel;

  truth_table_sequencer #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .y1(y1_1), .y2(y2_1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1),
    .tt1(tt1_1), .tt2(tt2_1), .diff(diff1), .first_diff(fd1), .pass(pass1)
  );

  truth_table_sequencer #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .y1(y1_3), .y2(y2_3),
    .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3),
    .tt1(tt1_3), .tt2(tt2_3), .diff(diff3), .first_diff(fd3), .pass(pass3)
  );

  function automatic logic maj_ao(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  function automatic logic maj_nn(input logic [2:0] v);
    return ~(~(v[2] & v[1]) & ~(v[2] & v[0]) & ~(v[1] & v[0]));
  endfunction

  // Two-cycle late copy of dut3's drive vector, for the slow-unit case.
  logic [2:0] dly1_3, dly2_3;
  always @(posedge clk) begin
    dly1_3 <= {a3, b3, c3};
    dly2_3 <= dly1_3;
  end

  // Function unit models.
  logic [2:0] v1, v3;
  always_comb begin
    v1   = {a1, b1, c1};
    y1_1 = maj_ao(v1);
    y2_1 = maj_nn(v1);
    case (mode)
      1: if (v1 == 3'd5) y2_1 = 1'b0;
      2: begin y1_1 = 1'b0; y2_1 = 1'b0; end
      3: begin y1_1 = tv1[v1]; y2_1 = tv2[v1]; end
      default: ;
    endcase
    v3   = {a3, b3, c3};
    y1_3 = (mode == 4) ? maj_ao(dly2_3) : maj_ao(v3);
    y2_3 = maj_nn(v3);
  end

  // Observation mux for the instance under test.
  logic       m_busy, m_done, m_diff, m_pass;
  logic [2:0] m_abc, m_fd;
  logic [7:0] m_tt1, m_tt2;
  assign m_busy = sel ? busy3 : busy1;
  assign m_done = sel ? done3 : done1;
  assign m_diff = sel ? diff3 : diff1;
  assign m_pass = sel ? pass3 : pass1;
  assign m_abc  = sel ? {a3, b3, c3} : {a1, b1, c1};
  assign m_fd   = sel ? fd3 : fd1;
  assign m_tt1  = sel ? tt1_3 : tt1_1;
  assign m_tt2  = sel ? tt2_3 : tt2_1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(m_busy), 32'd0);
    chk({tag, "_done"}, 32'(m_done), 32'd0);
    chk({tag, "_abc"},  32'(m_abc),  32'd0);
    chk({tag, "_tt1"},  32'(m_tt1),  32'd0);
    chk({tag, "_tt2"},  32'(m_tt2),  32'd0);
    chk({tag, "_diff"}, 32'(m_diff), 32'd0);
    chk({tag, "_fd"},   32'(m_fd),   32'd0);
    chk({tag, "_pass"}, 32'(m_pass), 32'd0);
  endtask

  // One full run; expectations come from the tables the unit should produce.
  task automatic run(input int settle, input logic [7:0] e1, input logic [7:0] e2,
                     input int pulse_at);
    logic       diff_e;
    logic [2:0] fd_e;
    logic       pass_e;
    diff_e = (e1 != e2);
    fd_e   = 3'd0;
    for (int i = 7; i >= 0; i--) if (e1[i] != e2[i]) fd_e = 3'(i);
    pass_e = !diff_e && (e1 == 8'hE8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clr_tt1", 32'(m_tt1), 32'd0);
    chk("clr_diff", 32'(m_diff), 32'd0);
    chk("clr_pass", 32'(m_pass), 32'd0);
    for (int v = 0; v < 8; v++) begin
      for (int s = 0; s < settle; s++) begin
        if (!(v == 0 && s == 0)) begin
          @(negedge clk);
          start = (v == pulse_at && s == 0) ? 1'b1 : 1'b0;
        end
        chk("run_busy", 32'(m_busy), 32'd1);
        chk("run_abc", 32'(m_abc), 32'(v));
        chk("run_done", 32'(m_done), 32'd0);
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("end_done", 32'(m_done), 32'd1);
    chk("end_busy", 32'(m_busy), 32'd0);
    chk("end_abc", 32'(m_abc), 32'd0);
    chk("end_tt1", 32'(m_tt1), 32'(e1));
    chk("end_tt2", 32'(m_tt2), 32'(e2));
    chk("end_diff", 32'(m_diff), 32'(diff_e));
    chk("end_fd", 32'(m_fd), 32'(fd_e));
    chk("end_pass", 32'(m_pass), 32'(pass_e));
    @(negedge clk);
    chk("post_done", 32'(m_done), 32'd0);
    chk("post_busy", 32'(m_busy), 32'd0);
    chk("post_tt1", 32'(m_tt1), 32'(e1));
    chk("post_pass", 32'(m_pass), 32'(pass_e));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0; mode = 0; tv1 = 8'd0; tv2 = 8'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Nominal majority, both forms.
    run(1, 8'hE8, 8'hE8, -1);
    // y2 stuck at 0 for index 5.
    mode = 1;
    run(1, 8'hE8, 8'hC8, -1);
    // Both outputs tied low: equal but wrong.
    mode = 2;
    run(1, 8'h00, 8'h00, -1);
    // start pulsed mid-run is ignored.
    mode = 0;
    run(1, 8'hE8, 8'hE8, 2);
    // Fresh run a few cycles after done.
    mode = 1;
    repeat (2) @(negedge clk);
    run(1, 8'hE8, 8'hC8, -1);

    // Reset at index 3 discards the partial run.
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_abc", 32'(m_abc), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midrst");
    @(negedge clk);
    chk("midrst_idle", 32'(m_busy), 32'd0);
    run(1, 8'hE8, 8'hE8, -1);

    // Randomised truth tables against the table-level model.
    mode = 3;
    for (int k = 0; k < 6; k++) begin
      tv1 = (k == 0) ? 8'hE8 : 8'($urandom);
      case (k % 3)
        0: tv2 = tv1;
        1: tv2 = tv1 ^ (8'd1 << $urandom_range(7, 0));
        default: tv2 = 8'($urandom);
      endcase
      run(1, tv1, tv2, -1);
    end

    // SETTLE=3 with a unit whose y1 lags by two cycles.
    sel = 1'b1;
    mode = 4;
    repeat (3) @(negedge clk);
    run(3, 8'hE8, 8'hE8, -1);
    mode = 0;
    run(3, 8'hE8, 8'hE8, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Sequences a 3-input, 2-output combinational function unit through all eight input combinations and captures both outputs into 8-bit truth-table registers. Flags any disagreement between the two outputs and checks output 1 against an expected truth table. Typical use: the function unit implements the same logic twice, once in AND-OR form and once in NAND-NAND form, and this block proves the two forms equivalent. Sits beside the function unit: drives its `a`, `b` and `c` inputs and samples its `y1` and `y2` outputs.

## Interface

Parameters:
- `SETTLE`, default 1: cycles each input vector is held before sampling; legal range 1..15.
- `EXPECTED`, default 8'hE8: expected truth table for `y1`, where bit i is the output for index i. The default is the 3-input majority function.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request a run; sampled only in IDLE.
- `y1`  input  1  function unit output 1 (for example, the AND-OR form).
- `y2`  input  1  function unit output 2 (for example, the NAND-NAND form).
- `a`, `b`, `c`  output  1 each  drive vector to the function unit: `a` = idx[2], `b` = idx[1], `c` = idx[0].
- `busy`  output  1  high while vectors are being applied.
- `done`  output  1  one-cycle pulse when a run completes.
- `tt1`  output  8  captured `y1` truth table.
- `tt2`  output  8  captured `y2` truth table.
- `diff`  output  1  sticky; set if `y1` != `y2` at any index in the current run.
- `first_diff`  output  3  index of the first disagreement; 0 if none.
- `pass`  output  1  valid from `done` onward: `!diff && (tt1 == EXPECTED)`.

## Operation

- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - `busy` = 0.
  - `a`, `b`, `c` hold 0.
  - Results from the previous run hold.
  - `start` = 1 → DRIVE. On the same edge: idx = 0, settle count = 0, `tt1`/`tt2`/`diff`/`first_diff`/`pass` cleared.
- DRIVE:
  - `busy` = 1; `a`, `b`, `c` driven from idx.
  - Settle counter increments every cycle.
  - On the cycle where the count equals SETTLE-1, at the end of that cycle:
    - `tt1[idx]` ← `y1`, `tt2[idx]` ← `y2`.
    - If `y1` != `y2` and `diff` is 0: `diff` ← 1 and `first_diff` ← idx.
    - Count ← 0.
    - If idx == 7 → DONE; otherwise idx ← idx + 1.
- DONE:
  - `done` = 1 for exactly one cycle; `pass` is registered on entry to DONE.
  - `busy` = 0; `a`, `b`, `c` return to 0.
  - → IDLE unconditionally.
- `start` is ignored in DRIVE and DONE. If `start` is held high continuously, a new run begins on the cycle after DONE.
- idx is 3 bits; the last vector is index 7. idx never wraps inside a run.

## Timing

- Reset values: FSM = IDLE; idx, count, `a`, `b`, `c`, `busy`, `done`, `tt1`, `tt2`, `diff`, `first_diff` and `pass` all 0.
- Edge E, where `start` is high in IDLE: `busy` and idx 0 are visible from E+1.
- Each vector is held for SETTLE cycles. `busy` stays high for 8×SETTLE cycles.
- `done` is high at cycle E + 8×SETTLE + 1. `tt1`, `tt2`, `diff` and `pass` are stable from then until the next start.
- `rst` has priority over everything. Reset mid-run returns every output to its reset value on the next edge; the partial run is discarded.
- Function-unit settling: the unit is combinational and must settle within SETTLE cycles minus setup time.

## Structure

- Shared package `tts_pkg`:
  - State encoding constants `S_IDLE` = 2'd0, `S_DRIVE` = 2'd1, `S_DONE` = 2'd2.
  - `MAJ3_TT` = 8'hE8, used as the default for `EXPECTED`.
- Sub-module `settle_timer`: a 4-bit counter with a clear input and a terminal-count output (`tc` = count == SETTLE-1).
- Top level holds the FSM, idx, the capture registers and the compare logic.

## Test plan

- **Nominal run:** reset, SETTLE=1, majority unit in both forms, single `start` pulse. Expect `a`/`b`/`c` to step 000→111 over 8 cycles, `done` at E+9, `tt1` = `tt2` = E8, `diff` = 0, `pass` = 1.
- **Fault injection:** force `y2` = 0 when idx = 5. Expect `tt2` = C8, `diff` = 1, `first_diff` = 5, `pass` = 0, `tt1` = E8.
- **Equal but wrong outputs:** tie `y1` = `y2` = 0. Expect `tt1` = `tt2` = 00, `diff` = 0, `pass` = 0.
- **Start handling:** pulse `start` at idx 2 → ignored, run completes normally. Pulse `start` 3 cycles after `done` → registers clear and a fresh 8-vector run executes.
- **Reset mid-run:** assert `rst` at idx 3. Next cycle shows all outputs 0 and IDLE. A following `start` gives `tt1` = E8.
- **Longer settle:** SETTLE=3. Each vector is held 3 cycles, `busy` lasts 24 cycles, and sampling occurs on the 3rd cycle of each vector. A unit that changes `y1` after 2 cycles is still captured correctly.
